// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline boundary: owns the committed N/V/Z flag register, resolves
// EX-stage branches against it, and registers result/store/control into MEM.
module ex_mem_stage #(
    parameter int DW = 16,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic          ex_valid,
    input  logic [3:0]    ex_opcode,
    input  logic [DW-1:0] ex_alu_result,
    input  logic [2:0]    ex_flags_new,
    input  logic [DW-1:0] ex_store_data,
    input  logic [RW-1:0] ex_dst_reg,
    input  logic          ex_reg_write,
    input  logic          ex_mem_read,
    input  logic          ex_mem_write,
    input  logic          ex_is_branch,
    input  logic [2:0]    ex_cond,
    output logic [2:0]    flags,
    output logic          branch_taken,
    output logic          mem_valid,
    output logic [DW-1:0] mem_alu_result,
    output logic [DW-1:0] mem_store_data,
    output logic [RW-1:0] mem_dst_reg,
    output logic          mem_reg_write,
    output logic          mem_mem_read,
    output logic          mem_mem_write
);

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_XOR = 4'h2;
    localparam logic [3:0] OP_SLL = 4'h4;
    localparam logic [3:0] OP_SRA = 4'h5;
    localparam logic [3:0] OP_ROR = 4'h6;

    logic [2:0]    r_flags;
    logic          r_valid;
    logic [DW-1:0] r_alu_result;
    logic [DW-1:0] r_store_data;
    logic [RW-1:0] r_dst_reg;
    logic          r_reg_write;
    logic          r_mem_read;
    logic          r_mem_write;

    logic          w_adv;
    logic [2:0]    w_flags_next;

    // Condition evaluated on {N,V,Z}; only ever fed the committed register.
    function automatic logic cond_met(input logic [2:0] f, input logic [2:0] c);
        logic n, v, z;
        n = f[2];
        v = f[1];
        z = f[0];
        case (c)
            3'b000:  cond_met = ~z;
            3'b001:  cond_met = z;
            3'b010:  cond_met = ~z & ~n;
            3'b011:  cond_met = n;
            3'b100:  cond_met = z | (~z & ~n);
            3'b101:  cond_met = n | z;
            3'b110:  cond_met = v;
            default: cond_met = 1'b1;
        endcase
    endfunction

    assign w_adv = ex_valid & ~stall & ~flush;

    always_comb begin
        w_flags_next = r_flags;
        if (w_adv) begin
            case (ex_opcode)
                OP_ADD, OP_SUB:         w_flags_next = ex_flags_new;
                OP_XOR, OP_SLL,
                OP_SRA, OP_ROR:         w_flags_next[0] = (ex_alu_result == '0);
                default:                w_flags_next = r_flags;
            endcase
        end
    end

    // Flags bypass is deliberately absent: a branch sees only committed flags.
    assign branch_taken = ex_valid & ex_is_branch & ~flush & cond_met(r_flags, ex_cond);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flags <= 3'b000;
        end else begin
            r_flags <= w_flags_next;
        end
    end

    // EX -> MEM boundary; flush outranks stall and leaves data fields untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_alu_result <= '0;
            r_store_data <= '0;
            r_dst_reg    <= '0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
        end else if (flush) begin
            r_valid      <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
        end else if (!stall) begin
            r_valid      <= ex_valid;
            r_alu_result <= ex_alu_result;
            r_store_data <= ex_store_data;
            r_dst_reg    <= ex_dst_reg;
            r_reg_write  <= ex_valid & ex_reg_write;
            r_mem_read   <= ex_valid & ex_mem_read;
            r_mem_write  <= ex_valid & ex_mem_write;
        end
    end

    assign flags          = r_flags;
    assign mem_valid      = r_valid;
    assign mem_alu_result = r_alu_result;
    assign mem_store_data = r_store_data;
    assign mem_dst_reg    = r_dst_reg;
    assign mem_reg_write  = r_reg_write;
    assign mem_mem_read   = r_mem_read;
    assign mem_mem_write  = r_mem_write;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: a reference model pushes expected MEM/flag
// state per edge into a queue that is popped and compared after each edge.
`timescale 1ns/100ps
module tb_ex_mem_stage;

    localparam logic [3:0] ADD = 4'h0, SUB = 4'h1, XOR = 4'h2, RED = 4'h3,
                           SLL = 4'h4, LW = 4'h8, SW = 4'h9, B = 4'hC, BR = 4'hD;

    logic        clk = 1'b0;
    logic        rst, stall, flush, ex_valid;
    logic [3:0]  ex_opcode;
    logic [15:0] ex_alu_result, ex_store_data;
    logic [2:0]  ex_flags_new, ex_cond;
    logic [3:0]  ex_dst_reg;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_is_branch;
    logic [2:0]  flags;
    logic        branch_taken, mem_valid;
    logic [15:0] mem_alu_result, mem_store_data;
    logic [3:0]  mem_dst_reg;
    logic        mem_reg_write, mem_mem_read, mem_mem_write;

    typedef struct packed {
        logic        v;
        logic [15:0] res;
        logic [15:0] sd;
        logic [3:0]  dst;
        logic        rw, mr, mw;
    } mem_t;

    typedef struct packed {
        mem_t       m;
        logic [2:0] f;
    } exp_t;

    exp_t sb[$];
    mem_t m_mem;
    logic [2:0] m_flags;
    int n_total = 0;
    int n_pass  = 0;

    ex_mem_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_alu_result(ex_alu_result),
        .ex_flags_new(ex_flags_new), .ex_store_data(ex_store_data),
        .ex_dst_reg(ex_dst_reg), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_is_branch(ex_is_branch), .ex_cond(ex_cond),
        .flags(flags), .branch_taken(branch_taken), .mem_valid(mem_valid),
        .mem_alu_result(mem_alu_result), .mem_store_data(mem_store_data),
        .mem_dst_reg(mem_dst_reg), .mem_reg_write(mem_reg_write),
        .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write)
    );

    always #50 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total += 1;
        assert (obs === exp) n_pass += 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic exp_taken(input logic [2:0] f, input logic [2:0] c);
        logic n, v, z;
        n = f[2]; v = f[1]; z = f[0];
        case (c)
            3'd0:    return !z;
            3'd1:    return z;
            3'd2:    return !z && !n;
            3'd3:    return n;
            3'd4:    return z || !n;
            3'd5:    return n || z;
            3'd6:    return v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic mem_t dut_mem();
        return '{mem_valid, mem_alu_result, mem_store_data, mem_dst_reg,
                 mem_reg_write, mem_mem_read, mem_mem_write};
    endfunction

    task automatic drive(input logic [3:0] op, input logic [15:0] res, input logic [2:0] fnew,
                         input logic [15:0] sd, input logic [3:0] dst, input logic rw,
                         input logic mr, input logic mw, input logic br, input logic [2:0] c);
        ex_valid = 1'b1;   ex_opcode = op;     ex_alu_result = res; ex_flags_new = fnew;
        ex_store_data = sd; ex_dst_reg = dst;  ex_reg_write = rw;   ex_mem_read = mr;
        ex_mem_write = mw; ex_is_branch = br;  ex_cond = c;
    endtask

    // Predict the state after the coming edge, push it, then compare after the edge.
    task automatic step();
        exp_t e;
        logic adv;
        adv = ex_valid && !stall && !flush;
        e.f = m_flags;
        if (adv) begin
            if (ex_opcode == ADD || ex_opcode == SUB)
                e.f = ex_flags_new;
            else if (ex_opcode inside {4'h2, 4'h4, 4'h5, 4'h6})
                e.f = {m_flags[2:1], ex_alu_result == 16'h0};
        end
        e.m = m_mem;
        if (flush) begin
            e.m.v = 1'b0; e.m.rw = 1'b0; e.m.mr = 1'b0; e.m.mw = 1'b0;
        end else if (!stall) begin
            e.m = '{ex_valid, ex_alu_result, ex_store_data, ex_dst_reg,
                    ex_valid & ex_reg_write, ex_valid & ex_mem_read, ex_valid & ex_mem_write};
        end
        sb.push_back(e);
        m_mem = e.m;
        m_flags = e.f;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("sb_mem", 64'(dut_mem()), 64'(e.m));
        chk("sb_flags", 64'(flags), 64'(e.f));
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        drive(ADD, 16'h0, 3'b000, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        ex_valid = 1'b0;
        m_mem = '0; m_flags = 3'b000;
        #12;
        chk("rst_flags", 64'(flags), 64'(3'b000));
        chk("rst_mem", 64'(dut_mem()), 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // reset asserted mid-cycle while traffic is in flight
        drive(ADD, 16'h1234, 3'b111, 16'h0, 4'h5, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
        step();
        chk("add_flags", 64'(flags), 64'(3'b111));
        #2 rst = 1'b1;
        #1;
        chk("async_rst_flags", 64'(flags), 64'(3'b000));
        chk("async_rst_valid", 64'(mem_valid), 64'(1'b0));
        m_mem = '0; m_flags = 3'b000;
        @(posedge clk); #1;
        chk("rst_hold_flags", 64'(flags), 64'(3'b000));
        chk("rst_hold_valid", 64'(mem_valid), 64'(1'b0));
        rst = 1'b0;

        // overflow ADD then branches on V and Z
        drive(ADD, 16'h7FFF, 3'b010, 16'h0, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
        step();
        chk("ovf_flags", 64'(flags), 64'(3'b010));
        chk("ovf_res", 64'(mem_alu_result), 64'(16'h7FFF));
        chk("ovf_valid", 64'(mem_valid), 64'(1'b1));
        drive(BR, 16'h0, 3'b000, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b110);
        #1 chk("br_v_taken", 64'(branch_taken), 64'(1'b1));
        ex_cond = 3'b001;
        #1 chk("br_z_not", 64'(branch_taken), 64'(1'b0));
        step();

        // Z-only updates for logical/shift ops; no effect from LW or RED
        drive(ADD, 16'h0001, 3'b100, 16'h0, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
        step();
        chk("set_n", 64'(flags), 64'(3'b100));
        drive(XOR, 16'h0000, 3'b000, 16'h0, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
        step();
        chk("xor_z", 64'(flags), 64'(3'b101));
        drive(SLL, 16'h0010, 3'b000, 16'h0, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
        step();
        chk("sll_nz", 64'(flags), 64'(3'b100));
        drive(RED, 16'h0000, 3'b011, 16'h0, 4'h4, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
        step();
        chk("red_hold", 64'(flags), 64'(3'b100));
        drive(LW, 16'h0040, 3'b111, 16'h0, 4'h6, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000);
        step();
        chk("lw_hold", 64'(flags), 64'(3'b100));

        // three-cycle stall with SUB in EX
        drive(SUB, 16'h5555, 3'b001, 16'h0, 4'h7, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
        stall = 1'b1;
        repeat (3) begin
            step();
            chk("stall_flags", 64'(flags), 64'(3'b100));
            chk("stall_res", 64'(mem_alu_result), 64'(16'h0040));
            chk("stall_mr", 64'(mem_mem_read), 64'(1'b1));
        end
        stall = 1'b0;
        step();
        chk("sub_flags", 64'(flags), 64'(3'b001));
        chk("sub_res", 64'(mem_alu_result), 64'(16'h5555));
        chk("sub_dst", 64'(mem_dst_reg), 64'(4'h7));

        // flush together with stall inserts a bubble
        drive(SW, 16'h0100, 3'b111, 16'hBEEF, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000);
        stall = 1'b1; flush = 1'b1;
        step();
        chk("fl_valid", 64'(mem_valid), 64'(1'b0));
        chk("fl_mw", 64'(mem_mem_write), 64'(1'b0));
        chk("fl_flags", 64'(flags), 64'(3'b001));
        stall = 1'b0;
        drive(ADD, 16'h0000, 3'b110, 16'h0, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
        step();
        chk("fl_add_flags", 64'(flags), 64'(3'b001));
        drive(B, 16'h0, 3'b000, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b111);
        #1 chk("fl_br", 64'(branch_taken), 64'(1'b0));
        flush = 1'b0;
        #1 chk("br_always", 64'(branch_taken), 64'(1'b1));
        step();

        // bubble with asserted control inputs is captured as zero control
        drive(ADD, 16'hFFFF, 3'b111, 16'h1111, 4'h9, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000);
        ex_valid = 1'b0;
        step();
        chk("inv_ctrl", 64'({mem_valid, mem_reg_write, mem_mem_read, mem_mem_write}), 64'(4'b0000));
        chk("inv_flags", 64'(flags), 64'(3'b001));

        // full condition sweep on every committed flag value
        for (int f = 0; f < 8; f++) begin
            drive(ADD, 16'h0, 3'(f), 16'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
            step();
            chk("sweep_flags", 64'(flags), 64'(f));
            drive(BR, 16'h0, 3'b000, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000);
            for (int c = 0; c < 8; c++) begin
                ex_valid = 1'b1; ex_cond = 3'(c);
                #1 chk($sformatf("cond_f%0d_c%0d", f, c), 64'(branch_taken),
                       64'(exp_taken(3'(f), 3'(c))));
                ex_valid = 1'b0;
                #1 chk($sformatf("inv_f%0d_c%0d", f, c), 64'(branch_taken), 64'(1'b0));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Pipeline stage boundary directly downstream of the 16-bit execute ALU.
- Holds the architectural N/V/Z flag register. The flag register output feeds the ALU flags_in port, and the ALU flag_out feeds back in as ex_flags_new.
- Resolves conditional branches in EX against the committed flags.
- Registers ALU result, store data and control into the MEM stage, with stall and flush support.

Parameters:
- DW, 16, datapath width of result and store data
- RW, 4, register-specifier width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- stall  in  1  hold the MEM-side registers and the flags
- flush  in  1  kill the instruction currently in EX; no flag update, bubble into MEM
- ex_valid  in  1  EX holds a real instruction
- ex_opcode  in  4  EX opcode (0 ADD, 1 SUB, 2 XOR, 3 RED, 4 SLL, 5 SRA, 6 ROR, 7 PADDSB, 8 LW, 9 SW, C B, D BR)
- ex_alu_result  in  DW  ALU rd output
- ex_flags_new  in  3  ALU flag_out, ordered {N,V,Z}
- ex_store_data  in  DW  rt value for SW
- ex_dst_reg  in  RW  destination register
- ex_reg_write  in  1  writeback enable
- ex_mem_read  in  1  load
- ex_mem_write  in  1  store
- ex_is_branch  in  1  B or BR in EX
- ex_cond  in  3  branch condition code
- flags  out  3  committed {N,V,Z}; drives ALU flags_in
- branch_taken  out  1  combinational taken decision for EX branch
- mem_valid  out  1  MEM holds a real instruction
- mem_alu_result  out  DW  registered result / address
- mem_store_data  out  DW  registered store data
- mem_dst_reg  out  RW  registered destination
- mem_reg_write  out  1  registered writeback enable
- mem_mem_read  out  1  registered load
- mem_mem_write  out  1  registered store

Behaviour:
- Reset (async, rst=1):
  - flags=3'b000.
  - mem_valid, mem_reg_write, mem_mem_read, mem_mem_write = 0.
  - mem_alu_result, mem_store_data = 0; mem_dst_reg = 0.
  - Takes effect mid-operation with no clock edge.
- Advance condition: adv = ex_valid & ~stall & ~flush.
- Flag update on a clock edge, only when adv:
  - Opcodes 0/1: flags <= ex_flags_new (all three bits).
  - Opcodes 2/4/5/6: Z <= (ex_alu_result == 0); N and V are held.
  - All other opcodes: flags held.
  - New flags are visible on the `flags` output the cycle after the setting instruction leaves EX. A branch immediately following therefore sees them with zero bypass.
- Branch decision:
  - branch_taken = ex_valid & ex_is_branch & ~flush & cond, where cond is evaluated on the current `flags` register:
    - 000: Z==0
    - 001: Z==1
    - 010: Z==0 & N==0
    - 011: N==1
    - 100: Z==1 | (Z==0 & N==0)
    - 101: N==1 | Z==1
    - 110: V==1
    - 111: always
  - Purely combinational; zero-cycle latency.
  - The flags-write path and the branch-condition path must not be merged. A branch never sees the flags of the instruction in EX with it.
- MEM register update per edge, highest priority first:
  - flush: mem_valid and all three mem control bits <= 0; data fields are don't-care but hold.
  - stall: all mem_* hold.
  - otherwise: all mem_* <= ex_* counterparts, with mem_valid <= ex_valid.
  - When ex_valid=0, the control bits are captured as 0 regardless of their inputs.
- Simultaneous stall & flush: flush wins; a bubble is inserted and flags are not written.
- Latency: one cycle EX->MEM. Throughput is one instruction per cycle when not stalled.
- RED, PADDSB, LW, SW and branches pass through with no flag effect.

Test Plan:
- Reset during traffic: drive ADD with ex_flags_new=3'b111, assert rst between edges -> flags=000 and mem_valid=0 immediately; still cleared after next edge while rst high.
- ADD 0x7FFF+1: ex_alu_result=0x7FFF, ex_flags_new=3'b010 -> next cycle flags=010, mem_alu_result=0x7FFF, mem_valid=1; following BR with ex_cond=110 -> branch_taken=1; with ex_cond=001 -> branch_taken=0.
- Masked update: flags=3'b100, then XOR with ex_alu_result=0 and ex_flags_new=000 -> flags=101; then SLL with result 0x0010 -> flags=100.
- Stall: hold stall=1 for 3 cycles with SUB (flags_new=001) in EX -> flags and mem_* unchanged for all 3; on release -> flags=001, mem_* captures SUB.
- Flush+stall together on SW (store data 0xBEEF, ex_mem_write=1) -> next cycle mem_valid=0, mem_mem_write=0, flags unchanged; branch in EX with flush=1 -> branch_taken=0.
- Condition sweep: for each flags value 000..111 and ex_cond 000..111 (64 cases), check branch_taken against the truth table; ex_valid=0 -> branch_taken=0 for all.
